cardinal_local_port: RTL and testbench
======================================

Name: cardinal_local_port

Overview:
Router-side endpoint of the PE/NIC link in the Cardinal ring router: the other end of the NIC's network input/output channels.
- Generates the router polarity.
- Ingress: accepts NIC-injected packets into two single-entry virtual-channel (VC) buffers and presents them to the router switch.
- Egress: accepts switch packets destined for the local PE into two single-entry VC buffers and delivers them to the NIC.
- VC rule: in a cycle with polarity P, VC P buffers may send; VC !P buffers may receive.

Parameters:
PAC_WIDTH, 64, packet width in bits; bit [0] is the VC bit.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
polarity  output  1  router polarity, registered; wired to NIC net_polarity
nic_si  input  1  send from NIC (NIC net_so)
nic_ri  output  1  ready to NIC (NIC net_ro)
nic_di  input  [0:PAC_WIDTH-1]  packet from NIC (NIC net_do)
nic_so  output  1  send to NIC (NIC net_si)
nic_ro  input  1  ready from NIC (NIC net_ri)
nic_do  output  [0:PAC_WIDTH-1]  packet to NIC (NIC net_di)
sw_si  input  1  send from switch (egress write request)
sw_ri  output  1  ready to switch
sw_di  input  [0:PAC_WIDTH-1]  packet from switch
sw_so  output  1  send to switch (ingress read)
sw_ro  input  1  ready from switch
sw_do  output  [0:PAC_WIDTH-1]  packet to switch
vc_err  output  1  sticky: a write arrived whose VC bit != !polarity

Behaviour:
- Reset, when high at the edge:
  - polarity=0.
  - All four buffer full bits=0 and data=0.
  - vc_err=0.
  - Consequences: nic_ri=1, sw_ri=1, nic_so=0, sw_so=0, nic_do=0, sw_do=0.
  - Reset mid-transfer discards all buffered packets; no partial state survives.
- Polarity: toggles every cycle out of reset (0,1,0,...). Every handshake below uses the current registered polarity P.
- Ingress buffers ing[0], ing[1]:
  - Write: nic_ri = ~ing[!P].full. Write ing[!P] when nic_si && nic_ri; data = nic_di, full<=1.
  - Read: sw_so = ing[P].full && sw_ro (combinational, same cycle). sw_do = ing[P].data whenever ing[P].full, else 0. When sw_so=1, ing[P].full<=0.
  - nic_si while nic_ri=0 is ignored; no overwrite, no error.
- Egress buffers egr[0], egr[1]: identical rules.
  - Write: sw_ri = ~egr[!P].full; write egr[!P] on sw_si && sw_ri.
  - Read: nic_so = egr[P].full && nic_ro; nic_do = egr[P].data when full, else 0; clear on nic_so.
- Simultaneous events:
  - Read and write always target different VCs within a cycle, so they never conflict.
  - All four buffers may change in one cycle.
- Latency: a packet written at polarity P is readable the next cycle, when polarity is !P, i.e. minimum 1 cycle through the block.
- Throughput: one packet per direction per cycle.
- VC check:
  - On any accepted write (ingress or egress), vc_err<=1 if data[0] != !P.
  - The packet is still stored in buffer !P; the VC bit is not rewritten.
  - vc_err clears only on reset.
- Data regs hold their value after read; only the full bit clears.

Decomposition:
- Shared package (cardinal_pkg):
  - PAC_WIDTH default.
  - VC_BIT index (0).
  - Localparams EVEN_VC=0, ODD_VC=1.
- One sub-module: cardinal_vc_buf, a single-entry buffer.
  - Ports: clk, reset, wen, ren, d_in, full, d_out.
  - ren has priority only on its own entry.
  - Instantiated 4x: ing[0..1], egr[0..1].
- Top level holds the polarity flop, VC muxing, handshake logic and vc_err.

Test Plan:
1. Reset for 2 cycles, then release → polarity 0,1,0,1; nic_ri=1, sw_ri=1, sw_so=0, nic_so=0, vc_err=0.
2. Ingress pass-through: at P=0 drive nic_si=1, nic_di=64'h8000_0000_0000_00AA, with sw_ro=1.
   - Next cycle (P=1): sw_so=1, sw_do=64'h8000_0000_0000_00AA.
   - Following cycle: sw_so=0, nic_ri=1.
3. Ingress backpressure: as in scenario 2 but sw_ro=0.
   - sw_so stays 0.
   - At the next P=0 cycle nic_ri=0; nic_si with 64'h8000_0000_0000_00BB is ignored.
   - Raising sw_ro at a P=1 cycle delivers ..AA, not ..BB.
4. Egress: at P=1 drive sw_si=1, sw_di=64'h0000_0000_0000_0055, with nic_ro=1 → next cycle (P=0) nic_so=1, nic_do=64'h0000_0000_0000_0055. With nic_ro=0 the packet is held and re-offered each P=0 cycle.
5. Full duplex: every cycle inject matching-VC packets on both NIC and switch with both ready=1 → one packet per direction per cycle, order preserved, no drops over 100 cycles, vc_err=0.
6. Error and reset: at P=0 write nic_di=64'h0000_0000_0000_0001 (VC bit 0).
   - vc_err=1 and stays high.
   - Packet is readable at P=1.
   - Reset asserted mid-transfer → vc_err=0, all full=0, polarity=0 on the next edge.

Source files
------------

// File: rtl/cardinal_pkg.sv
// Shared constants for the Cardinal ring router local port.
package cardinal_pkg;

  localparam int DEF_PAC_WIDTH = 64;
  localparam int VC_BIT        = 0;
  localparam logic EVEN_VC     = 1'b0;
  localparam logic ODD_VC      = 1'b1;

endpackage

// File: rtl/cardinal_vc_buf.sv
// Single-entry virtual-channel buffer: one packet plus a full flag.
module cardinal_vc_buf
  import cardinal_pkg::*;
#(
  parameter int W = DEF_PAC_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wen,
  input  logic         ren,
  input  logic [0:W-1] d_in,
  output logic         full,
  output logic [0:W-1] d_out
);

  logic         full_q, full_d;
  logic [0:W-1] data_q, data_d;

  // Data is left in place after a read; only the full flag drops.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (ren) begin
      full_d = 1'b0;
    end else if (wen) begin
      full_d = 1'b1;
      data_d = d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full  = full_q;
  assign d_out = data_q;

endmodule

// File: rtl/cardinal_local_port.sv
// Router-side end of the PE/NIC link: polarity generator, two ingress and two
// egress single-entry VC buffers, and a sticky VC-bit error flag.
module cardinal_local_port
  import cardinal_pkg::*;
#(
  parameter int PAC_WIDTH = DEF_PAC_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 polarity,
  input  logic                 nic_si,
  output logic                 nic_ri,
  input  logic [0:PAC_WIDTH-1] nic_di,
  output logic                 nic_so,
  input  logic                 nic_ro,
  output logic [0:PAC_WIDTH-1] nic_do,
  input  logic                 sw_si,
  output logic                 sw_ri,
  input  logic [0:PAC_WIDTH-1] sw_di,
  output logic                 sw_so,
  input  logic                 sw_ro,
  output logic [0:PAC_WIDTH-1] sw_do,
  output logic                 vc_err
);

  // Handshakes: a transfer happens in a cycle where send and ready are both
  // high. VC P buffers may only send, VC !P buffers may only receive.
  logic polarity_q, polarity_d;
  logic vc_err_q, vc_err_d;
  logic pol, npol;
  logic nic_wr, sw_wr;

  logic [1:0]           ing_wen, ing_ren, ing_full;
  logic [1:0]           egr_wen, egr_ren, egr_full;
  logic [0:PAC_WIDTH-1] ing_data [2];
  logic [0:PAC_WIDTH-1] egr_data [2];

  for (genvar v = 0; v < 2; v++) begin : g_vc
    cardinal_vc_buf #(.W(PAC_WIDTH)) u_ing (
      .clk   (clk),
      .reset (reset),
      .wen   (ing_wen[v]),
      .ren   (ing_ren[v]),
      .d_in  (nic_di),
      .full  (ing_full[v]),
      .d_out (ing_data[v])
    );
    cardinal_vc_buf #(.W(PAC_WIDTH)) u_egr (
      .clk   (clk),
      .reset (reset),
      .wen   (egr_wen[v]),
      .ren   (egr_ren[v]),
      .d_in  (sw_di),
      .full  (egr_full[v]),
      .d_out (egr_data[v])
    );
  end

  always_comb begin
    pol  = polarity_q;
    npol = ~polarity_q;
  end

  // Ingress: NIC writes VC !P, switch reads VC P.
  always_comb begin
    nic_ri        = ~ing_full[npol];
    nic_wr        = nic_si & nic_ri;
    sw_so         = ing_full[pol] & sw_ro;
    sw_do         = ing_full[pol] ? ing_data[pol] : '0;
    ing_wen       = '0;
    ing_wen[npol] = nic_wr;
    ing_ren       = '0;
    ing_ren[pol]  = sw_so;
  end

  // Egress: switch writes VC !P, NIC reads VC P.
  always_comb begin
    sw_ri         = ~egr_full[npol];
    sw_wr         = sw_si & sw_ri;
    nic_so        = egr_full[pol] & nic_ro;
    nic_do        = egr_full[pol] ? egr_data[pol] : '0;
    egr_wen       = '0;
    egr_wen[npol] = sw_wr;
    egr_ren       = '0;
    egr_ren[pol]  = nic_so;
  end

  // A mislabelled packet is still stored; the flag only records the fault.
  always_comb begin
    polarity_d = ~polarity_q;
    vc_err_d   = vc_err_q
               | (nic_wr & (nic_di[VC_BIT] != npol))
               | (sw_wr  & (sw_di[VC_BIT]  != npol));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      polarity_q <= EVEN_VC;
      vc_err_q   <= 1'b0;
    end else begin
      polarity_q <= polarity_d;
      vc_err_q   <= vc_err_d;
    end
  end

  assign polarity = polarity_q;
  assign vc_err   = vc_err_q;

endmodule

// File: tb/tb_cardinal_local_port.sv
// Directed and randomized checks of cardinal_local_port against a buffer-level
// reference model and an in-order packet scoreboard.
module tb_cardinal_local_port;

  typedef logic [0:63] pkt_t;

  localparam pkt_t PKT_AA = 64'h8000_0000_0000_00AA;
  localparam pkt_t PKT_BB = 64'h8000_0000_0000_00BB;
  localparam pkt_t PKT_55 = 64'h0000_0000_0000_0055;
  localparam pkt_t PKT_01 = 64'h0000_0000_0000_0001;

  logic clk = 1'b0;
  logic reset;
  logic polarity;
  logic nic_si, nic_ri, nic_so, nic_ro;
  logic sw_si, sw_ri, sw_so, sw_ro;
  pkt_t nic_di, nic_do, sw_di, sw_do;
  logic vc_err;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: per-VC slot contents, polarity, sticky error.
  bit   pol;
  bit   err;
  bit   ing_v [2];
  pkt_t ing_d [2];
  bit   egr_v [2];
  pkt_t egr_d [2];

  // In-order scoreboards for the full-duplex run.
  logic [63:0] ing_exp_q[$];
  logic [63:0] egr_exp_q[$];

  always #5 clk = ~clk;

  cardinal_local_port #(.PAC_WIDTH(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .nic_si   (nic_si),
    .nic_ri   (nic_ri),
    .nic_di   (nic_di),
    .nic_so   (nic_so),
    .nic_ro   (nic_ro),
    .nic_do   (nic_do),
    .sw_si    (sw_si),
    .sw_ri    (sw_ri),
    .sw_di    (sw_di),
    .sw_so    (sw_so),
    .sw_ro    (sw_ro),
    .sw_do    (sw_do),
    .vc_err   (vc_err)
  );

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "time limit expired");
  end

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_p(input string tag, input pkt_t obs, input pkt_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pol = 1'b0;
    err = 1'b0;
    for (int v = 0; v < 2; v++) begin
      ing_v[v] = 1'b0;
      egr_v[v] = 1'b0;
      ing_d[v] = '0;
      egr_d[v] = '0;
    end
  endtask

  // Called at a negedge with inputs applied: checks outputs, advances the
  // model by one clock, and returns at the following negedge.
  task automatic tick();
    bit p, np;
    #2;
    p  = pol;
    np = !pol;
    chk_b("polarity", polarity, p);
    chk_b("nic_ri",   nic_ri,   !ing_v[np]);
    chk_b("sw_ri",    sw_ri,    !egr_v[np]);
    chk_b("sw_so",    sw_so,    ing_v[p] && sw_ro);
    chk_p("sw_do",    sw_do,    ing_v[p] ? ing_d[p] : '0);
    chk_b("nic_so",   nic_so,   egr_v[p] && nic_ro);
    chk_p("nic_do",   nic_do,   egr_v[p] ? egr_d[p] : '0);
    chk_b("vc_err",   vc_err,   err);
    if (reset) begin
      model_reset();
    end else begin
      if (sw_ro && ing_v[p]) ing_v[p] = 1'b0;
      if (nic_ro && egr_v[p]) egr_v[p] = 1'b0;
      if (nic_si && !ing_v[np]) begin
        ing_v[np] = 1'b1;
        ing_d[np] = nic_di;
        if (nic_di[0] != np) err = 1'b1;
      end
      if (sw_si && !egr_v[np]) begin
        egr_v[np] = 1'b1;
        egr_d[np] = sw_di;
        if (sw_di[0] != np) err = 1'b1;
      end
      pol = !pol;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_pol(input bit p);
    if (pol != p) tick();
  endtask

  function automatic pkt_t rand_pkt(input bit vc);
    pkt_t r;
    r    = {$urandom, $urandom};
    r[0] = vc;
    return r;
  endfunction

  initial begin
    pkt_t exp_pkt;
    int   n_ing_del, n_egr_del;
    reset  = 1'b1;
    nic_si = 1'b0; nic_ro = 1'b0; nic_di = '0;
    sw_si  = 1'b0; sw_ro  = 1'b0; sw_di  = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    reset = 1'b0;

    // Post-reset idle: polarity 0,1,0,1, both sides ready, nothing sent.
    repeat (4) tick();

    // Ingress pass-through.
    wait_pol(1'b0);
    sw_ro = 1'b1; nic_si = 1'b1; nic_di = PKT_AA;
    tick();
    nic_si = 1'b0;
    #1 chk_p("s2_sw_do", sw_do, PKT_AA);
    chk_b("s2_sw_so", sw_so, 1'b1);
    tick();
    tick();

    // Ingress backpressure: the second packet is refused.
    wait_pol(1'b0);
    sw_ro = 1'b0; nic_si = 1'b1; nic_di = PKT_AA;
    tick();
    nic_si = 1'b0;
    tick();
    nic_si = 1'b1; nic_di = PKT_BB;
    #1 chk_b("s3_nic_ri", nic_ri, 1'b0);
    tick();
    nic_si = 1'b0; sw_ro = 1'b1;
    #1 chk_p("s3_sw_do", sw_do, PKT_AA);
    tick();
    tick();

    // Egress delivery, then hold and re-offer under nic_ro=0.
    wait_pol(1'b1);
    nic_ro = 1'b1; sw_si = 1'b1; sw_di = PKT_55;
    tick();
    sw_si = 1'b0;
    #1 chk_p("s4_nic_do", nic_do, PKT_55);
    tick();
    wait_pol(1'b1);
    nic_ro = 1'b0; sw_si = 1'b1; sw_di = PKT_55;
    tick();
    sw_si = 1'b0;
    repeat (4) tick();
    nic_ro = 1'b1;
    #1 chk_b("s4_nic_so_release", nic_so, 1'b1);
    tick();
    tick();

    // Full duplex: one packet per direction per cycle, in order.
    sw_ro = 1'b1; nic_ro = 1'b1;
    n_ing_del = 0; n_egr_del = 0;
    for (int i = 0; i < 101; i++) begin
      nic_si = (i < 100); sw_si = (i < 100);
      nic_di = rand_pkt(!pol);
      sw_di  = rand_pkt(!pol);
      #1;
      if (sw_so === 1'b1) begin
        if (ing_exp_q.size() == 0) chk_b("s5_ing_q_empty", 1'b1, 1'b0);
        else begin
          exp_pkt = ing_exp_q.pop_front();
          chk_p("s5_sw_order", sw_do, exp_pkt);
        end
        n_ing_del++;
      end
      if (nic_so === 1'b1) begin
        if (egr_exp_q.size() == 0) chk_b("s5_egr_q_empty", 1'b1, 1'b0);
        else begin
          exp_pkt = egr_exp_q.pop_front();
          chk_p("s5_nic_order", nic_do, exp_pkt);
        end
        n_egr_del++;
      end
      if (i < 100) begin
        ing_exp_q.push_back(nic_di);
        egr_exp_q.push_back(sw_di);
      end
      tick();
    end
    nic_si = 1'b0; sw_si = 1'b0;
    chk_p("s5_ing_count", pkt_t'(n_ing_del), pkt_t'(100));
    chk_p("s5_egr_count", pkt_t'(n_egr_del), pkt_t'(100));
    chk_b("s5_vc_err", vc_err, 1'b0);

    // Randomized traffic with correct VC labels.
    for (int i = 0; i < 200; i++) begin
      nic_si = 1'($urandom_range(0, 1));
      sw_si  = 1'($urandom_range(0, 1));
      nic_ro = 1'($urandom_range(0, 1));
      sw_ro  = 1'($urandom_range(0, 1));
      nic_di = rand_pkt(!pol);
      sw_di  = rand_pkt(!pol);
      tick();
    end
    nic_si = 1'b0; sw_si = 1'b0; sw_ro = 1'b1; nic_ro = 1'b1;
    tick();
    tick();

    // Mislabelled packet, sticky error, then reset mid-transfer.
    wait_pol(1'b0);
    sw_ro = 1'b0; nic_si = 1'b1; nic_di = PKT_01;
    tick();
    nic_si = 1'b0; sw_ro = 1'b1;
    #1 chk_b("s6_vc_err_set", vc_err, 1'b1);
    chk_p("s6_sw_do", sw_do, PKT_01);
    tick();
    sw_ro = 1'b0; nic_ro = 1'b0;
    nic_si = 1'b1; nic_di = rand_pkt(1'b1);
    tick();
    nic_si = 1'b0;
    sw_si = 1'b1; sw_di = rand_pkt(1'b0);
    tick();
    sw_si = 1'b0;
    chk_b("s6_vc_err_hold", vc_err, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1 chk_b("s6_rst_pol", polarity, 1'b0);
    chk_b("s6_rst_err", vc_err, 1'b0);
    chk_b("s6_rst_nic_ri", nic_ri, 1'b1);
    chk_b("s6_rst_sw_ri", sw_ri, 1'b1);
    sw_ro = 1'b1; nic_ro = 1'b1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
